mac_pe: RTL and testbench
=========================

# mac_pe

Systolic processing element that sits directly downstream of `data_feeder`. It consumes one 8-bit operand per enable from a row feeder (A) and a column feeder (B), accumulates K products into a full-precision sum, and forwards both operands one cycle later to its east/south neighbours. A finished dot product is presented on a valid/ready result port and held until drained.

## Interface
Parameters:
- `DATA_W`, 8: operand width, unsigned.
- `K`, 7: products per dot product; matches the 7-byte feeder depth.
- `ACC_W`, `2*DATA_W + $clog2(K)` = 19: accumulator and result width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that clears the accumulator and begins a new dot product.
- `en`  in  1  operand-valid strobe, same cycle as `a_in`/`b_in`.
- `a_in`  in  DATA_W  operand from the west, or from the row feeder.
- `b_in`  in  DATA_W  operand from the north, or from the column feeder.
- `a_out`  out  DATA_W  registered copy of `a_in`, to the east.
- `b_out`  out  DATA_W  registered copy of `b_in`, to the south.
- `en_out`  out  1  registered copy of `en`.
- `busy`  out  1  high in ACCUM.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  ACC_W  completed dot product.

## Operation
- States: IDLE, ACCUM, HOLD. Internal registers: `acc` (ACC_W bits) and `cnt` (0..K-1).
- **IDLE**
  - `start` → ACCUM.
  - If `en` is also high in the same cycle: `acc` = a*b and `cnt` = 1. Otherwise `acc` = 0 and `cnt` = 0.
  - `en` without `start` is forwarded only and is not accumulated.
- **ACCUM**
  - Each `en`: `acc` += a*b and `cnt` increments.
  - On the `en` that makes K products: `res_data` takes the final sum, `res_valid` goes to 1, state → HOLD.
  - `start` in ACCUM aborts and restarts, with the same rules as `start` in IDLE (the product of that cycle counts if `en` is high). The partial result is discarded and never presented.
- **HOLD**
  - `res_valid` = 1. `res_data` is stable until the handshake.
  - `res_valid && res_ready` → IDLE.
  - If `start` is high in the handshake cycle → ACCUM directly, applying the IDLE `start` rules.
  - `start` without `res_ready` is ignored, because the result must not be lost.
  - `en` in HOLD is forwarded only.
- Forwarding of `a`, `b` and `en` is unconditional in every state, so the systolic wavefront never stalls.
- Arithmetic:
  - Unsigned DATA_W × DATA_W → 2·DATA_W product, zero-extended to ACC_W.
  - Overflow cannot occur: the maximum is 255·255·7 = 455175 < 2^19.
- K = 1 is legal: `start`+`en` completes immediately into HOLD.

## Timing
- Reset values: `a_out` = 0, `b_out` = 0, `en_out` = 0, `busy` = 0, `res_valid` = 0, `res_data` = 0, state IDLE, `acc` = 0, `cnt` = 0.
- Operand forward latency is 1 cycle: `a_out` at cycle n+1 equals `a_in` at cycle n.
- Result latency: `res_valid` rises on the clock edge that samples the K-th `en`, and is visible the following cycle.
- Minimum dot-product period is K cycles plus 1 handshake cycle, or K cycles if `start` coincides with the accepting `res_ready`.
- All outputs are registered. No combinational path from any input to any output.
- Asserting `reset_n` low mid-operation immediately returns every register to its reset value, asynchronously. The pending result is lost.

## Structure
- Package `mac_pkg` holds:
  - `DATA_W`, `K`, `ACC_W` localparam defaults.
  - The `pe_state_t` enum {IDLE, ACCUM, HOLD}.
  - The `cnt` width constant, `$clog2(K)`.
- Single module with no sub-module. The multiplier is inferred inline.
- The array wrapper instantiates an N×N grid of `mac_pe`, fed by `data_feeder` instances on the west and north edges.

## Test plan
- Reset, then `start`+`en` with a = 1..7 (one per cycle) and b = 2 constant → `res_valid` the cycle after the 7th `en`, `res_data` = 56, `busy` low in HOLD.
- All operands 255 over K = 7 → `res_data` = 455175, with no wrap.
- Result held with `res_ready` = 0 for 5 cycles while `en` keeps toggling → `res_data` stable at 56, `res_valid` stays 1, and `a_out`/`b_out` still follow the inputs with 1-cycle delay.
- `start` on the 4th `en` of a run, with 3 products already summed → the old sum is discarded, `cnt` restarts at 1, and the next `res_data` covers only the new 7 products.
- `res_ready` and `start`+`en` in the same HOLD cycle → 56 accepted, ACCUM entered with `cnt` = 1, no idle cycle.
- `reset_n` pulsed low during ACCUM at `cnt` = 3 → all outputs 0 in the same cycle, state IDLE, later `en` not accumulated until `start`.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the systolic MAC processing element.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int K      = 7;
  localparam int ACC_W  = 2*DATA_W + $clog2(K);
  // Counter width; kept at least 1 bit so K = 1 still yields a legal vector.
  localparam int CNT_W  = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pe_state_t;

endpackage

// File: rtl/mac_pe.sv
// Systolic MAC PE: accumulates K unsigned products per dot product, forwards
// operands east/south with one cycle of latency, and presents the finished sum
// on a valid/ready port that holds until drained.
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int K      = 7,
  parameter int ACC_W  = 2*DATA_W + $clog2(K)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              en_out,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);
  import mac_pkg::*;

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  pe_state_t           state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    res_q, res_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, vld_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                en_q;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext, sum;
  logic                load;

  assign prod     = a_in * b_in;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_q + prod_ext;

  // Next-state: a start that is honoured (any state but HOLD-without-ready)
  // seeds the accumulator with this cycle's product when en is high.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    load    = 1'b0;
    case (state_q)
      IDLE:  load = start;
      ACCUM: begin
        if (start) begin
          load = 1'b1;
        end else if (en) begin
          acc_d = sum;
          if (cnt_q == CW'(K-1)) begin
            res_d   = sum;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (start) load = 1'b1;
          else       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      if (en) begin
        acc_d = prod_ext;
        if (K == 1) begin
          res_d   = prod_ext;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d   = CW'(1);
          state_d = ACCUM;
        end
      end else begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACCUM;
      end
    end
  end

  // Control/datapath registers; status flags are registered from next state
  // so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= (state_d == ACCUM);
      vld_q   <= (state_d == HOLD);
    end
  end

  // Unconditional operand forwarding keeps the systolic wavefront moving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      en_q <= 1'b0;
    end else begin
      a_q  <= a_in;
      b_q  <= b_in;
      en_q <= en;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign en_out    = en_q;
  assign busy      = busy_q;
  assign res_valid = vld_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_mac_pe.sv
// Directed self-checking bench for mac_pe (K = 7, DATA_W = 8).
module tb_mac_pe;
  localparam int DATA_W = 8;
  localparam int K      = 7;
  localparam int ACC_W  = 19;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, en, res_ready;
  logic [DATA_W-1:0] a_in, b_in;
  logic [DATA_W-1:0] a_out, b_out;
  logic              en_out, busy, res_valid;
  logic [ACC_W-1:0]  res_data;

  int n_cmp = 0;
  int n_bad = 0;

  mac_pe #(.DATA_W(DATA_W), .K(K), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .en(en),
    .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
    .en_out(en_out), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic e, input int a, input int b, input logic r);
    start = s; en = e; a_in = DATA_W'(a); b_in = DATA_W'(b); res_ready = r;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #3;
    n_cmp++; if ({a_out, b_out, en_out, busy, res_valid} !== '0) begin n_bad++;
      $display("FAIL reset_outs: got a=%0d b=%0d en=%b busy=%b vld=%b want all 0", a_out, b_out, en_out, busy, res_valid); end
    n_cmp++; if (res_data !== 19'd0) begin n_bad++;
      $display("FAIL reset_res: got %0d want 0", res_data); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // start+en with a = 1..7, b = 2: result 56 visible the cycle after the 7th en.
  task automatic test_basic();
    for (int i = 1; i <= K; i++) begin
      drive(i == 1, 1, i, 2, 0);
      tick();
      if (i == 1) begin
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
      end
      if (i == K - 1) begin
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", res_valid); end
      end
    end
    n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", res_valid); end
    n_cmp++; if (res_data !== 19'd56) begin n_bad++; $display("FAIL basic_data: got %0d want 56", res_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_hold: got %b want 0", busy); end
    n_cmp++; if (a_out !== 8'd7 || b_out !== 8'd2 || en_out !== 1'b1) begin n_bad++;
      $display("FAIL basic_fwd: got a=%0d b=%0d en=%b want 7 2 1", a_out, b_out, en_out); end
  endtask

  // Result stays put for 5 unready cycles while forwarding keeps running.
  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      drive(0, i[0], 10 + i, 40 + i, 0);
      tick();
      n_cmp++; if (res_valid !== 1'b1 || res_data !== 19'd56) begin n_bad++;
        $display("FAIL hold_stable[%0d]: got vld=%b data=%0d want 1 56", i, res_valid, res_data); end
      n_cmp++; if (a_out !== 8'(10 + i) || b_out !== 8'(40 + i) || en_out !== i[0]) begin n_bad++;
        $display("FAIL hold_fwd[%0d]: got a=%0d b=%0d en=%b want %0d %0d %b", i, a_out, b_out, en_out, 10 + i, 40 + i, i[0]); end
    end
  endtask

  // Handshake and start+en coincide: straight into ACCUM with cnt = 1.
  task automatic test_back_to_back();
    drive(1, 1, 1, 2, 1);
    tick();
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL b2b_state: got vld=%b busy=%b want 0 1", res_valid, busy); end
    n_cmp++; if (dut.cnt_q !== 3'd1) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 1", dut.cnt_q); end
    for (int i = 2; i <= K; i++) begin drive(0, 1, i, 2, 0); tick(); end
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 19'd56) begin n_bad++;
      $display("FAIL b2b_data: got vld=%b data=%0d want 1 56", res_valid, res_data); end
    drive(0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL b2b_drain: got vld=%b busy=%b want 0 0", res_valid, busy); end
  endtask

  // All-ones operands: 255*255*7 = 455175 fits in 19 bits.
  task automatic test_max();
    for (int i = 0; i < K; i++) begin drive(i == 0, 1, 255, 255, 0); tick(); end
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 19'd455175) begin n_bad++;
      $display("FAIL max_data: got vld=%b data=%0d want 1 455175", res_valid, res_data); end
    drive(0, 0, 0, 0, 1); tick();
  endtask

  // Restart on the 4th en after 1*2+2*2+3*2 = 12 was summed; new run is 7*(3*3) = 63.
  task automatic test_abort();
    for (int i = 1; i <= 3; i++) begin drive(i == 1, 1, i, 2, 0); tick(); end
    drive(1, 1, 3, 3, 0);
    tick();
    n_cmp++; if (dut.cnt_q !== 3'd1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL abort_cnt: got cnt=%0d busy=%b want 1 1", dut.cnt_q, busy); end
    for (int i = 0; i < K - 1; i++) begin drive(0, 1, 3, 3, 0); tick(); end
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 19'd63) begin n_bad++;
      $display("FAIL abort_data: got vld=%b data=%0d want 1 63", res_valid, res_data); end
    drive(0, 0, 0, 0, 1); tick();
  endtask

  // en without start is ignored; start without en clears; start in HOLD without ready is ignored.
  task automatic test_idle_en();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 5, 5, 0); tick(); end
    n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_bad++;
      $display("FAIL idle_en: got busy=%b vld=%b want 0 0", busy, res_valid); end
    drive(1, 0, 9, 9, 0); tick();
    for (int i = 0; i < K; i++) begin drive(0, 1, 1, 1, 0); tick(); end
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 19'd7) begin n_bad++;
      $display("FAIL start_no_en: got vld=%b data=%0d want 1 7", res_valid, res_data); end
    drive(1, 1, 4, 4, 0); tick();
    n_cmp++; if (res_valid !== 1'b1 || res_data !== 19'd7 || busy !== 1'b0) begin n_bad++;
      $display("FAIL hold_start_ignored: got vld=%b data=%0d busy=%b want 1 7 0", res_valid, res_data, busy); end
    drive(0, 0, 0, 0, 1); tick();
  endtask

  // Asynchronous reset mid-accumulation clears everything before the next edge.
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin drive(i == 0, 1, 1, 1, 0); tick(); end
    n_cmp++; if (dut.cnt_q !== 3'd3) begin n_bad++; $display("FAIL areset_pre_cnt: got %0d want 3", dut.cnt_q); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({a_out, b_out, en_out, busy, res_valid} !== '0 || res_data !== 19'd0) begin n_bad++;
      $display("FAIL areset_outs: got a=%0d b=%0d en=%b busy=%b vld=%b data=%0d want all 0",
               a_out, b_out, en_out, busy, res_valid, res_data); end
    n_cmp++; if (dut.state_q !== mac_pkg::IDLE || dut.cnt_q !== 3'd0) begin n_bad++;
      $display("FAIL areset_state: got state=%0d cnt=%0d want 0 0", dut.state_q, dut.cnt_q); end
    #2 reset_n = 1'b1;
    for (int i = 0; i < K + 1; i++) begin drive(0, 1, 2, 2, 0); tick(); end
    n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_bad++;
      $display("FAIL areset_no_accum: got busy=%b vld=%b want 0 0", busy, res_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_max();
    test_abort();
    test_idle_en();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
